// File: rtl/fifo_flit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flit_serializer
// Description : Pops packets from the packet FIFO and serializes each one onto
//               a valid/ready flit link, least-significant flit first, with a
//               last-flit marker for downstream reassembly.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flit_serializer #(
    parameter int PACKET_WIDTH = 40,
    parameter int FLIT_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_fifo_empty,
    input  logic [PACKET_WIDTH-1:0] i_fifo_packet,
    output logic                    o_fifo_rd_en,
    output logic [FLIT_WIDTH-1:0]   o_flit,
    output logic                    o_flit_valid,
    output logic                    o_flit_last,
    input  logic                    i_flit_ready,
    output logic                    o_busy
);

    // Flits per packet; the shift register is padded up to a whole number of
    // flits so the upper bits of a short final flit read as zero.
    localparam int c_NUM_FLITS = (PACKET_WIDTH + FLIT_WIDTH - 1) / FLIT_WIDTH;
    localparam int c_SR_WIDTH  = c_NUM_FLITS * FLIT_WIDTH;
    localparam int c_CNT_WIDTH = (c_NUM_FLITS > 1) ? $clog2(c_NUM_FLITS) : 1;

    localparam logic [c_CNT_WIDTH-1:0] c_LAST_CNT = c_CNT_WIDTH'(c_NUM_FLITS - 1);
    localparam logic [c_CNT_WIDTH-1:0] c_CNT_ONE  = c_CNT_WIDTH'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_POP  = 2'd1;
    localparam logic [1:0] c_ST_LOAD = 2'd2;
    localparam logic [1:0] c_ST_SEND = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [c_SR_WIDTH-1:0]  r_shift;
    logic [c_CNT_WIDTH-1:0] r_cnt;

    logic w_send;
    logic w_last;
    logic w_xfer;

    // Link-side decode comes purely from registered state so valid never
    // depends on ready and read-enable is glitch-free.
    assign w_send       = (r_state == c_ST_SEND);
    assign w_last       = (r_cnt == c_LAST_CNT);
    assign w_xfer       = w_send & i_flit_ready;

    assign o_fifo_rd_en = (r_state == c_ST_POP);
    assign o_flit_valid = w_send;
    assign o_flit_last  = w_send & w_last;
    assign o_flit       = r_shift[FLIT_WIDTH-1:0];
    assign o_busy       = (r_state != c_ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the empty flag matters only in IDLE and on the
    // final flit transfer, which allows back-to-back packets without idling.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!i_fifo_empty) begin
                    w_state_next = c_ST_POP;
                end
            end
            c_ST_POP: begin
                w_state_next = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                w_state_next = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (w_xfer && w_last) begin
                    w_state_next = i_fifo_empty ? c_ST_IDLE : c_ST_POP;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Shift register and flit counter: load the popped packet one cycle
    // after the read pulse, then shift one flit out per accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (r_state == c_ST_LOAD) begin
            r_shift <= c_SR_WIDTH'(i_fifo_packet);
            r_cnt   <= '0;
        end else if (w_xfer && !w_last) begin
            r_shift <= r_shift >> FLIT_WIDTH;
            r_cnt   <= r_cnt + c_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_flit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_flit_serializer
// Description : Scoreboard bench for fifo_flit_serializer (8-bit and 16-bit
//               flit instances) fed by a one-cycle-latency FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flit_serializer;

    localparam int PW = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // ---------------- 8-bit flit instance ----------------
    logic [PW-1:0] fifo_q[$];
    logic [PW-1:0] fifo_data  = '0;
    logic          fifo_empty = 1'b1;
    logic          rd_en;
    logic [7:0]    flit;
    logic          valid, last, busy;
    logic          ready = 1'b1;

    fifo_flit_serializer #(.PACKET_WIDTH(PW), .FLIT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_fifo_empty(fifo_empty), .i_fifo_packet(fifo_data),
        .o_fifo_rd_en(rd_en), .o_flit(flit), .o_flit_valid(valid),
        .o_flit_last(last), .i_flit_ready(ready), .o_busy(busy)
    );

    // ---------------- 16-bit flit instance ----------------
    logic [PW-1:0] fifo16_q[$];
    logic [PW-1:0] fifo16_data  = '0;
    logic          fifo16_empty = 1'b1;
    logic          rd_en16;
    logic [15:0]   flit16;
    logic          valid16, last16, busy16;
    logic          ready16 = 1'b1;

    fifo_flit_serializer #(.PACKET_WIDTH(PW), .FLIT_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .i_fifo_empty(fifo16_empty), .i_fifo_packet(fifo16_data),
        .o_fifo_rd_en(rd_en16), .o_flit(flit16), .o_flit_valid(valid16),
        .o_flit_last(last16), .i_flit_ready(ready16), .o_busy(busy16)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_q[$];     // {last, flit}
    logic [16:0] exp16_q[$];   // {last, flit}

    int cyc = 0;
    int rd_count = 0;
    int xfers = 0;
    int lasts = 0;
    int last_rd_cyc = 0;
    bit have_rd = 0;
    bit gap_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: data appears the cycle after the read pulse.
    always @(posedge clk) begin
        if (rd_en) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_overread: rd_en=1 with FIFO size=0 (required no read)");
            end else begin
                fifo_data <= fifo_q.pop_front();
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
        if (rd_en16) begin
            if (fifo16_q.size() != 0) fifo16_data <= fifo16_q.pop_front();
            fifo16_empty <= (fifo16_q.size() == 0);
        end
    end

    // Monitor for the 8-bit instance: scoreboard, hold checks, pop spacing.
    logic       p_valid = 0, p_ready = 0, p_last = 0, p_rst = 0;
    logic [7:0] p_flit = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && p_rst && p_valid && !p_ready) begin
            checks++;
            if (!(valid === 1'b1 && flit === p_flit && last === p_last)) begin
                errors++;
                $display("FAIL hold: valid=%0b flit=%02h last=%0b, required valid=1 flit=%02h last=%0b",
                         valid, flit, last, p_flit, p_last);
            end
        end
        if (rst_n && valid && ready) begin
            checks++;
            xfers++;
            if (last) lasts++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got flit=%02h last=%0b, required no flit", flit, last);
            end else begin
                e = exp_q.pop_front();
                if ({last, flit} !== e) begin
                    errors++;
                    $display("FAIL flit: got flit=%02h last=%0b, required flit=%02h last=%0b",
                             flit, last, e[7:0], e[8]);
                end
            end
        end
        if (rst_n && rd_en) begin
            rd_count++;
            if (gap_en && have_rd) begin
                checks++;
                if (cyc - last_rd_cyc != 7) begin
                    errors++;
                    $display("FAIL rd_gap: got %0d cycles, required 7", cyc - last_rd_cyc);
                end
            end
            last_rd_cyc = cyc;
            have_rd = 1;
        end
        p_valid = valid; p_ready = ready; p_last = last; p_flit = flit; p_rst = rst_n;
    end

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n && valid16 && ready16) begin
            checks++;
            if (exp16_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit16: got flit=%04h last=%0b, required no flit", flit16, last16);
            end else begin
                e = exp16_q.pop_front();
                if ({last16, flit16} !== e) begin
                    errors++;
                    $display("FAIL flit16: got flit=%04h last=%0b, required flit=%04h last=%0b",
                             flit16, last16, e[15:0], e[16]);
                end
            end
        end
    end

    // Queue a packet in the FIFO and its five LSB-first flits in the scoreboard.
    task automatic push_pkt(input logic [PW-1:0] pkt, input bit with_exp);
        fifo_q.push_back(pkt);
        fifo_empty = 1'b0;
        if (with_exp) begin
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back({(i == 4), pkt[i*8 +: 8]});
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Wait (bounded) until the 8-bit path drains, then confirm it stays idle.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(!busy && fifo_empty && exp_q.size() == 0) && n < 300);
        check_val({name, "_timeout"}, (n < 300) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #2;
        check_val({name, "_idle_busy"}, int'(busy), 0);
        check_val({name, "_idle_valid"}, int'(valid), 0);
        check_val({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int base_rd, base_x, base_l, n;

        // ---------- reset with a non-empty FIFO ----------
        push_pkt(40'h0A0B0C0D0E, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check_val("rst_rd_en", int'(rd_en), 0);
            check_val("rst_valid", int'(valid), 0);
            check_val("rst_busy", int'(busy), 0);
        end
        check_val("rst_flit", int'(flit), 0);
        check_val("rst_last", int'(last), 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check_val("first_rd_en_after_rst", int'(rd_en), 1);
        // ---------- single packet ----------
        wait_idle("single");
        check_val("single_rd_count", rd_count, 1);
        check_val("single_lasts", lasts, 1);

        // ---------- back-pressure on the third flit ----------
        base_rd = rd_count; base_x = xfers;
        push_pkt(40'h0A0B0C0D0E, 1);
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(valid && flit == 8'h0C) && n < 50);
        check_val("bp_find_0C", (n < 50) ? 1 : 0, 1);
        ready = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_val("bp_still_0C", int'(flit), 8'h0C);
        ready = 1'b1;
        wait_idle("bp");
        check_val("bp_rd_count", rd_count - base_rd, 1);
        check_val("bp_xfers", xfers - base_x, 5);

        // ---------- three back-to-back packets ----------
        base_rd = rd_count; base_l = lasts;
        have_rd = 0; gap_en = 1;
        push_pkt(40'h1413121110, 1);
        push_pkt(40'h2423222120, 1);
        push_pkt(40'h3433323130, 1);
        wait_idle("b2b");
        gap_en = 0;
        check_val("b2b_rd_count", rd_count - base_rd, 3);
        check_val("b2b_lasts", lasts - base_l, 3);

        // ---------- reset after the second flit ----------
        base_x = xfers;
        push_pkt(40'h5554535251, 0);
        push_pkt(40'h6564636261, 1);
        exp_q.push_front({1'b0, 8'h52});
        exp_q.push_front({1'b0, 8'h51});
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (xfers != base_x + 2 && n < 50);
        check_val("mr_two_xfers", (n < 50) ? 1 : 0, 1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check_val("mr_valid_after_rst", int'(valid), 0);
        check_val("mr_busy_after_rst", int'(busy), 0);
        rst_n = 1'b1;
        base_rd = rd_count;
        @(posedge clk); #2;
        check_val("mr_fresh_pop", int'(rd_en), 1);
        wait_idle("mr");
        check_val("mr_rd_count", rd_count - base_rd, 1);

        // ---------- padding with 16-bit flits ----------
        fifo16_q.push_back(40'h0A0B0C0D0E);
        fifo16_empty = 1'b0;
        exp16_q.push_back({1'b0, 16'h0D0E});
        exp16_q.push_back({1'b0, 16'h0B0C});
        exp16_q.push_back({1'b1, 16'h000A});
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(exp16_q.size() == 0 && !busy16 && fifo16_empty) && n < 100);
        check_val("pad_done", (n < 100) ? 1 : 0, 1);
        repeat (2) @(posedge clk);
        #2;
        check_val("pad_busy", int'(busy16), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
